core_wb_arbiter: RTL and testbench
==================================

# core_wb_arbiter

Write-back arbiter that owns the single write port of the general-purpose register file (`wb`, `wb_addr`, `wb_data`). It merges results from the ALU (single-cycle, priority) and the load/store unit (variable latency, buffered in a small FIFO) into one registered write per cycle. A starvation counter guarantees forward progress for load returns. It sits at the end of the execute/memory stages, directly in front of the GPR file.

## Interface
- `LQ_DEPTH`, 4: load-return FIFO entries; power of two, minimum 2.
- `STARVE_LIMIT`, 3: consecutive cycles a non-empty FIFO may go undrained before ALU is blocked; minimum 1.

- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present
- `alu_ready`  out  1  ALU result accepted this cycle when `alu_valid && alu_ready`
- `alu_addr`  in  reg_addr_t  ALU destination register
- `alu_data`  in  data_t  ALU result
- `lsu_valid`  in  1  load data present
- `lsu_ready`  out  1  FIFO can accept
- `lsu_addr`  in  reg_addr_t  load destination register
- `lsu_data`  in  data_t  load data
- `wb`  out  1  write enable to GPR file, registered
- `wb_addr`  out  reg_addr_t  write address, registered
- `wb_data`  out  data_t  write data, registered
- `lq_empty`  out  1  FIFO empty, used by issue logic for drain/flush

## Operation
- **FIFO push:** `lsu_valid && lsu_ready`. `lsu_ready = !full`, derived from the registered count only. No push while full, even if a pop happens in the same cycle.
- **Selection, evaluated each cycle in priority order:**
  1. `force && !empty`: pop the FIFO head.
  2. `alu_valid`: take the ALU result.
  3. `!empty`: pop the FIFO head.
  4. Otherwise: no write.
- **Readiness:**
  - `alu_ready = !force`, combinational from registered state.
  - An ALU result is not consumed while `alu_ready` is low; the producer holds it.
- **Starvation counter `starve_cnt`,** width clog2(STARVE_LIMIT+1):
  - Cleared on reset, on a pop, and whenever the FIFO is empty.
  - Incremented (saturating) on each cycle the FIFO is non-empty and not popped.
  - `force = (starve_cnt == STARVE_LIMIT)`.
- **Push and pop in one cycle:**
  - Allowed when the FIFO is not full; count is unchanged.
  - When empty, a pushed entry is not visible for pop until the next cycle; there is no FIFO bypass.
- **FIFO pointers:** clog2(LQ_DEPTH) bits, wrap naturally. Count is clog2(LQ_DEPTH)+1 bits.
- **Ordering:** WAW ordering between ALU and load results to the same register is guaranteed by issue logic. This block writes strictly in selection order.

## Timing
- **Reset values:**
  - `wb`=0, `wb_addr`=0, `wb_data`=0.
  - `lsu_ready`=1, `alu_ready`=1, `lq_empty`=1.
  - Pointers, count and `starve_cnt` are 0.
- **Latency:**
  - ALU input to `wb`: 1 cycle.
  - Load input to `wb`: minimum 2 cycles (push, then pop-register).
- **Throughput:** exactly one GPR write per cycle maximum.
- **Reset mid-operation:**
  - FIFO contents are discarded.
  - `wb` drops to 0 asynchronously; no partial write is issued after reset deasserts.
- `wb_addr` and `wb_data` hold their last values when `wb`=0.

## Configuration
- **`CORE_WB_BYPASS_EN` defined:** adds the following ports.
  - Inputs `byp_a_addr` and `byp_b_addr` (reg_addr_t).
  - Outputs `byp_a_hit` and `byp_b_hit` (1 bit) and `byp_data` (data_t).
  - `byp_x_hit = wb && (wb_addr == byp_x_addr)`, combinational from the registered outputs.
  - `byp_data = wb_data`.
  - Decode uses these to forward the in-flight write.
- **Not defined:** the ports and logic are absent. The consumer must stall one cycle on a read-after-write to the same register.

## Structure
- `reg_addr_t` and `data_t` come from the shared core defines.
- Add the `CORE_WB_LQ_DEPTH` and `CORE_WB_STARVE_LIMIT` defaults to the shared defines.
- One sub-module: `core_wb_fifo`.
  - Parameterised synchronous FIFO with `push`, `pop`, `full`, `empty`, head data.
  - Stores addr+data.
  - Reused later for store buffering.

## Test plan
- **ALU only:** reset, `alu_valid`=1, `alu_addr`=3, `alu_data`=0x1234 -> next cycle `wb`=1, `wb_addr`=3, `wb_data`=0x1234; `lsu_ready`=1 throughout.
- **Load only:** push `lsu_addr`=5, `lsu_data`=0xAA55 with the ALU idle -> `wb` with addr 5, data 0xAA55 two cycles after the push; `lq_empty` returns to 1.
- **Fill FIFO:** push 4 loads while `alu_valid`=1 continuously.
  - `lsu_ready` falls after the 4th push.
  - After 3 undrained cycles, `alu_ready`=0 for one cycle and the oldest load is written.
  - The counter restarts from 0.
- **Simultaneous:** ALU addr 1 and load addr 2 presented in the same cycle with an empty FIFO -> ALU writes first (cycle+1) and the load writes at cycle+2 when the ALU is idle.
- **Reset mid-operation:** 3 loads queued, assert `rst_n`=0 -> `wb`=0 immediately and `lq_empty`=1; after release, no stale write appears.
- **Bypass (`CORE_WB_BYPASS_EN`):** `wb` to reg 7 with `byp_a_addr`=7 and `byp_b_addr`=6 -> `byp_a_hit`=1, `byp_b_hit`=0, `byp_data` equals `wb_data`.

Source files
------------

// File: rtl/core_wb_arbiter_pkg.sv
// Shared core types for the GPR write-back path, plus write-back arbiter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  // Defaults for the write-back arbiter.
  localparam int CORE_WB_LQ_DEPTH     = 4;
  localparam int CORE_WB_STARVE_LIMIT = 3;

  // One load-return entry: destination register plus the loaded value.
  typedef struct packed {
    reg_addr_t addr;
    data_t     data;
  } lq_entry_t;

endpackage

// File: rtl/core_wb_fifo.sv
// Generic synchronous FIFO holding W-bit entries; head entry is always visible.
// Latency: a pushed entry becomes visible at the head one cycle later (no bypass).
// Backpressure: full derives from the registered count; push while full is dropped, pop while empty ignored.
module core_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  // Full blocks a push even when a pop happens in the same cycle.
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_full     = (r_count == DEPTH_C);
  assign o_empty    = (r_count == '0);
  assign o_head_dat = r_mem[r_rd_ptr];

  // Storage array: written at the tail, no reset needed since count gates validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// GPR write-port arbiter: ALU results (priority) and buffered load returns merged into one registered write.
// Latency: ALU 1 cycle to wb; load minimum 2 cycles (push, then pop into the write register).
// Backpressure: lsu_ready = !full; alu_ready drops for one cycle when a queued load has starved STARVE_LIMIT cycles.
// Optional: define CORE_WB_BYPASS_EN to add decode forwarding ports (byp_*).
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int LQ_DEPTH     = CORE_WB_LQ_DEPTH,
  parameter int STARVE_LIMIT = CORE_WB_STARVE_LIMIT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [REG_ADDR_W-1:0] i_alu_addr,
  input  logic [DATA_W-1:0]     i_alu_data,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [REG_ADDR_W-1:0] i_lsu_addr,
  input  logic [DATA_W-1:0]     i_lsu_data,
  output logic                  o_wb,
  output logic [REG_ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0]     o_wb_data,
  output logic                  o_lq_empty
`ifdef CORE_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] i_byp_a_addr,
  input  logic [REG_ADDR_W-1:0] i_byp_b_addr,
  output logic                  o_byp_a_hit,
  output logic                  o_byp_b_hit,
  output logic [DATA_W-1:0]     o_byp_data
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  lq_entry_t     w_push_ent;
  lq_entry_t     w_head_ent;
  logic          w_full;
  logic          w_empty;
  logic          w_force;
  logic          w_pop;
  logic          w_take_alu;
  logic [SW-1:0] r_starve_cnt;
  logic          r_wb;
  reg_addr_t     r_wb_addr;
  data_t         r_wb_data;

  assign w_push_ent.addr = i_lsu_addr;
  assign w_push_ent.data = i_lsu_data;

  core_wb_fifo #(
    .DEPTH (LQ_DEPTH),
    .W     ($bits(lq_entry_t))
  ) u_lq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (i_lsu_valid && o_lsu_ready),
    .i_push_dat (w_push_ent),
    .i_pop      (w_pop),
    .o_head_dat (w_head_ent),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Selection: a starved load wins, then the ALU, then any queued load.
  assign w_force    = (r_starve_cnt == STARVE_MAX);
  assign w_pop      = !w_empty && (w_force || !i_alu_valid);
  assign w_take_alu = i_alu_valid && !w_force;

  assign o_alu_ready = !w_force;
  assign o_lsu_ready = !w_full;
  assign o_lq_empty  = w_empty;
  assign o_wb        = r_wb;
  assign o_wb_addr   = r_wb_addr;
  assign o_wb_data   = r_wb_data;

  // Starvation counter: counts cycles a non-empty queue goes undrained, saturating at the limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_empty || w_pop) begin
      r_starve_cnt <= '0;
    end else if (!w_force) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Write register: one GPR write per cycle; address/data hold their last value when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb      <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb <= w_pop || w_take_alu;
      if (w_pop) begin
        r_wb_addr <= w_head_ent.addr;
        r_wb_data <= w_head_ent.data;
      end else if (w_take_alu) begin
        r_wb_addr <= i_alu_addr;
        r_wb_data <= i_alu_data;
      end
    end
  end

`ifdef CORE_WB_BYPASS_EN
  // Forward the in-flight write to decode when a source register matches it.
  assign o_byp_a_hit = r_wb && (r_wb_addr == i_byp_a_addr);
  assign o_byp_b_hit = r_wb && (r_wb_addr == i_byp_b_addr);
  assign o_byp_data  = r_wb_data;
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter with hand-computed expected values.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: exercised by filling the load queue and watching the starvation override.
module tb_core_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        wb;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lq_empty;
`ifdef CORE_WB_BYPASS_EN
  logic [4:0]  byp_a_addr;
  logic [4:0]  byp_b_addr;
  logic        byp_a_hit;
  logic        byp_b_hit;
  logic [31:0] byp_data;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  core_wb_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_alu_valid (alu_valid),
    .o_alu_ready (alu_ready),
    .i_alu_addr  (alu_addr),
    .i_alu_data  (alu_data),
    .i_lsu_valid (lsu_valid),
    .o_lsu_ready (lsu_ready),
    .i_lsu_addr  (lsu_addr),
    .i_lsu_data  (lsu_data),
    .o_wb        (wb),
    .o_wb_addr   (wb_addr),
    .o_wb_data   (wb_data),
    .o_lq_empty  (lq_empty)
`ifdef CORE_WB_BYPASS_EN
    ,
    .i_byp_a_addr (byp_a_addr),
    .i_byp_b_addr (byp_b_addr),
    .o_byp_a_hit  (byp_a_hit),
    .o_byp_b_hit  (byp_b_hit),
    .o_byp_data   (byp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_addr  = '0;
    lsu_data  = '0;
`ifdef CORE_WB_BYPASS_EN
    byp_a_addr = '0;
    byp_b_addr = '0;
`endif
    #2;
    chk("rst_wb",        wb,        1'b0);
    chk("rst_wb_addr",   wb_addr,   5'd0);
    chk("rst_wb_data",   wb_data,   32'd0);
    chk("rst_lsu_ready", lsu_ready, 1'b1);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_lq_empty",  lq_empty,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU only: one-cycle latency, address/data hold afterwards.
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1234;
    chk("alu_ready_pre", alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    chk("alu_wb",        wb,        1'b1);
    chk("alu_wb_addr",   wb_addr,   5'd3);
    chk("alu_wb_data",   wb_data,   32'h1234);
    chk("alu_lsu_ready", lsu_ready, 1'b1);
    tick();
    chk("idle_wb",       wb,        1'b0);
    chk("hold_wb_addr",  wb_addr,   5'd3);
    chk("hold_wb_data",  wb_data,   32'h1234);

    // Load only: push, then written two edges after presentation.
    lsu_valid = 1'b1; lsu_addr = 5'd5; lsu_data = 32'hAA55;
    tick();
    lsu_valid = 1'b0;
    chk("ld_push_wb",    wb,        1'b0);
    chk("ld_push_empty", lq_empty,  1'b0);
    tick();
    chk("ld_wb",         wb,        1'b1);
    chk("ld_wb_addr",    wb_addr,   5'd5);
    chk("ld_wb_data",    wb_data,   32'hAA55);
    chk("ld_empty_back", lq_empty,  1'b1);
    tick();
    chk("ld_idle_wb",    wb,        1'b0);

    // Simultaneous ALU and load into an empty queue: ALU first, load next.
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_addr = 5'd2; lsu_data = 32'h22;
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("sim_alu_addr",  wb_addr,   5'd1);
    chk("sim_alu_data",  wb_data,   32'h11);
    chk("sim_lq_busy",   lq_empty,  1'b0);
    tick();
    chk("sim_ld_wb",     wb,        1'b1);
    chk("sim_ld_addr",   wb_addr,   5'd2);
    chk("sim_ld_data",   wb_data,   32'h22);
    tick();
    chk("sim_idle_wb",   wb,        1'b0);

    // Fill: four loads under continuous ALU traffic, then starvation override.
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(10 + i); alu_data = 32'h200 + i;
      lsu_valid = 1'b1; lsu_addr = 5'(20 + i); lsu_data = 32'h100 + i;
      tick();
      chk("fill_alu_addr", wb_addr, 5'(10 + i));
    end
    lsu_valid = 1'b0;
    chk("fill_lsu_full",   lsu_ready, 1'b0);
    chk("fill_force",      alu_ready, 1'b0);
    alu_addr = 5'd14; alu_data = 32'h204;
    tick();
    chk("force_ld_addr",   wb_addr,   5'd20);
    chk("force_ld_data",   wb_data,   32'h100);
    chk("force_released",  alu_ready, 1'b1);
    tick();
    chk("held_alu_addr",   wb_addr,   5'd14);
    chk("held_alu_data",   wb_data,   32'h204);
    chk("after_pop_ready", lsu_ready, 1'b1);
    chk("cnt1_ready",      alu_ready, 1'b1);
    alu_addr = 5'd15; alu_data = 32'h205;
    tick();
    chk("cnt2_ready",      alu_ready, 1'b1);
    alu_addr = 5'd16; alu_data = 32'h206;
    tick();
    chk("cnt3_alu_addr",   wb_addr,   5'd16);
    chk("cnt3_force",      alu_ready, 1'b0);
    alu_valid = 1'b0;
    tick();
    chk("drain_l1_addr",   wb_addr,   5'd21);
    tick();
    tick();
    chk("drain_l3_addr",   wb_addr,   5'd23);
    chk("drain_l3_data",   wb_data,   32'h103);
    chk("drain_empty",     lq_empty,  1'b1);
    tick();

    // Reset with three loads queued behind ALU traffic.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(8 + i); alu_data = 32'h300 + i;
      lsu_valid = 1'b1; lsu_addr = 5'(25 + i); lsu_data = 32'h400 + i;
      tick();
    end
    chk("pre_rst_wb",      wb,        1'b1);
    chk("pre_rst_busy",    lq_empty,  1'b0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb",      wb,        1'b0);
    chk("mid_rst_empty",   lq_empty,  1'b1);
    chk("mid_rst_lsu_rdy", lsu_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_wb", wb, 1'b0);
    end
    chk("post_rst_empty",  lq_empty,  1'b1);

`ifdef CORE_WB_BYPASS_EN
    // Bypass: in-flight write to r7 matches port A only.
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h7777;
    tick();
    alu_valid = 1'b0;
    byp_a_addr = 5'd7; byp_b_addr = 5'd6;
    #1;
    chk("byp_a_hit",       byp_a_hit, 1'b1);
    chk("byp_b_hit",       byp_b_hit, 1'b0);
    chk("byp_data",        byp_data,  32'h7777);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
